// File: rtl/obi_stall_pkg.sv
// -----------------------------------------------------------------------------
// obi_stall_pkg
// Shared types and constants for the OBI grant-stall injector.
//   stall_mode_e : per-channel stall mode (NONE, STANDARD, RANDOM, RSVD)
//   ch_state_e   : per-channel handshake FSM state (IDLE, STALL, OPEN)
//   LFSR_TAPS    : Galois toggle mask for x^32 + x^22 + x^2 + x + 1
//   LFSR_DEFAULT_SEED : base seed; channel c is seeded with seed ^ c
// -----------------------------------------------------------------------------
package obi_stall_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        STANDARD = 2'b01,
        RANDOM   = 2'b10,
        RSVD     = 2'b11
    } stall_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STALL = 2'b01,
        OPEN  = 2'b10
    } ch_state_e;

    localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_2468;

    // One right-shifting Galois step: the bit shifted out toggles the taps.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/obi_stall_lfsr.sv
// -----------------------------------------------------------------------------
// obi_stall_lfsr
// 32-bit Galois LFSR (taps 32,22,2,1) that advances one step per enabled cycle.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, loads SEED
//   en_i    : advance the sequence this cycle
//   state_o : current 32-bit LFSR state
// -----------------------------------------------------------------------------
module obi_stall_lfsr
    import obi_stall_pkg::*;
#(
    parameter logic [31:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = en_i ? lfsr_next(state_q) : state_q;
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/obi_multi_gnt_stall.sv
// -----------------------------------------------------------------------------
// obi_multi_gnt_stall
// Delays the OBI grant of N_CH independent request channels by a programmable
// (fixed or pseudo-random) number of cycles, and counts stalled cycles.
// Optional feature macro: OBI_STALL_RANDOM_EN -- when defined, each channel
// gets its own LFSR and RANDOM mode draws a delay in 0..max_stall; when not
// defined, no LFSR exists and RANDOM mode behaves like NONE (delay 0).
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   req_core_i      : [N_CH] core requests
//   req_mem_o       : [N_CH] requests forwarded to memory once the stall ends
//   gnt_mem_i       : [N_CH] memory grants
//   gnt_core_o      : [N_CH] grants returned to the core
//   en_stall_i      : global stall enable
//   stall_mode_i    : [2*N_CH] per-channel stall_mode_e
//   fixed_stall_i   : [CNT_W*N_CH] STANDARD delay per channel
//   max_stall_i     : [CNT_W*N_CH] RANDOM upper bound per channel
//   clr_i           : clear stall counters (dominates increment)
//   stall_o         : [N_CH] request pending and not granted this cycle
//   stall_cnt_o     : [16*N_CH] saturating stalled-cycle counters
// -----------------------------------------------------------------------------
module obi_multi_gnt_stall
    import obi_stall_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned CNT_W     = 8,
    parameter logic [31:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_CH-1:0]       req_core_i,
    output logic [N_CH-1:0]       req_mem_o,
    input  logic [N_CH-1:0]       gnt_mem_i,
    output logic [N_CH-1:0]       gnt_core_o,
    input  logic                  en_stall_i,
    input  logic [2*N_CH-1:0]     stall_mode_i,
    input  logic [CNT_W*N_CH-1:0] fixed_stall_i,
    input  logic [CNT_W*N_CH-1:0] max_stall_i,
    input  logic                  clr_i,
    output logic [N_CH-1:0]       stall_o,
    output logic [16*N_CH-1:0]    stall_cnt_o
);

`ifndef OBI_STALL_RANDOM_EN
    // The RANDOM bound has no consumer when the LFSRs are compiled out.
    logic max_stall_unused;
    assign max_stall_unused = ^max_stall_i;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch

        stall_mode_e      mode;
        ch_state_e        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] delay, rnd_delay;
        logic [15:0]      scnt_q, scnt_d;
        logic             req, gnt_mem, open, gnt, stall;

        assign req     = req_core_i[c];
        assign gnt_mem = gnt_mem_i[c];
        assign mode    = stall_mode_e'(stall_mode_i[2*c +: 2]);

`ifdef OBI_STALL_RANDOM_EN
        logic [31:0]  lfsr_state;
        logic [CNT_W:0] max_p1;
        logic         lfsr_unused;

        // Advances once per request seen in IDLE, i.e. once per delay draw.
        obi_stall_lfsr #(
            .SEED (LFSR_SEED ^ 32'(c))
        ) u_lfsr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (req && (state_q == IDLE)),
            .state_o (lfsr_state)
        );

        // The extra bit keeps max_stall+1 from wrapping to 0 at the top value.
        assign max_p1      = {1'b0, max_stall_i[CNT_W*c +: CNT_W]} + {{CNT_W{1'b0}}, 1'b1};
        assign rnd_delay   = CNT_W'({1'b0, lfsr_state[CNT_W-1:0]} % max_p1);
        assign lfsr_unused = ^lfsr_state[31:CNT_W];
`else
        assign rnd_delay = '0;
`endif

        // Delay for a new transaction; only consumed in IDLE, so mode and
        // limit changes during STALL/OPEN have no effect.
        always_comb begin
            delay = '0;
            if (en_stall_i) begin
                case (mode)
                    STANDARD: delay = fixed_stall_i[CNT_W*c +: CNT_W];
                    RANDOM:   delay = rnd_delay;
                    default:  delay = '0;
                endcase
            end
        end

        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            open    = 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (delay == '0) begin
                            // Zero delay is pure pass-through in the same cycle.
                            open    = 1'b1;
                            state_d = gnt_mem ? IDLE : OPEN;
                        end else if (delay == CNT_W'(1)) begin
                            state_d = OPEN;
                        end else begin
                            // This cycle counts as the first of the d stall cycles.
                            state_d = STALL;
                            cnt_d   = delay - CNT_W'(1);
                        end
                    end
                end
                STALL: begin
                    if (!req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_d = OPEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                OPEN: begin
                    open = 1'b1;
                    if (!req || gnt_mem) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are gated by reset so nothing leaks through while rst_ni is low.
        assign gnt   = rst_ni & req & open & gnt_mem;
        assign stall = rst_ni & req & ~gnt;

        always_comb begin
            scnt_d = scnt_q;
            if (clr_i) begin
                scnt_d = '0;
            end else if (stall && (scnt_q != 16'hFFFF)) begin
                scnt_d = scnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                scnt_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                scnt_q  <= scnt_d;
            end
        end

        assign req_mem_o[c]            = rst_ni & req & open;
        assign gnt_core_o[c]           = gnt;
        assign stall_o[c]              = stall;
        assign stall_cnt_o[16*c +: 16] = scnt_q;

    end

endmodule

// File: tb/tb_obi_multi_gnt_stall.sv
// -----------------------------------------------------------------------------
// tb_obi_multi_gnt_stall
// Directed bench for obi_multi_gnt_stall (N_CH=2, CNT_W=8). A transaction-level
// model predicts every output on every cycle: a request seen with no open
// transaction starts one at cycle T with delay d; the channel is open from
// cycle T+d on; a grant or a dropped request ends the transaction.
// Directed sequences add literal latency / counter expectations.
// -----------------------------------------------------------------------------
module tb_obi_multi_gnt_stall;

    localparam int          N_CH  = 2;
    localparam int          CNT_W = 8;
    localparam logic [31:0] SEED  = 32'hACE1_2468;

    logic                  clk_i;
    logic                  rst_ni;
    logic [N_CH-1:0]       req_core_i;
    logic [N_CH-1:0]       req_mem_o;
    logic [N_CH-1:0]       gnt_mem_i;
    logic [N_CH-1:0]       gnt_core_o;
    logic                  en_stall_i;
    logic [2*N_CH-1:0]     stall_mode_i;
    logic [CNT_W*N_CH-1:0] fixed_stall_i;
    logic [CNT_W*N_CH-1:0] max_stall_i;
    logic                  clr_i;
    logic [N_CH-1:0]       stall_o;
    logic [16*N_CH-1:0]    stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    obi_multi_gnt_stall #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .LFSR_SEED (SEED)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_core_i    (req_core_i),
        .req_mem_o     (req_mem_o),
        .gnt_mem_i     (gnt_mem_i),
        .gnt_core_o    (gnt_core_o),
        .en_stall_i    (en_stall_i),
        .stall_mode_i  (stall_mode_i),
        .fixed_stall_i (fixed_stall_i),
        .max_stall_i   (max_stall_i),
        .clr_i         (clr_i),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          act_tr [N_CH];
    int          t_start[N_CH];
    int          dly    [N_CH];
    logic [31:0] m_lfsr [N_CH];
    int          m_cnt  [N_CH];

    function automatic logic [31:0] m_lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic int model_delay(input int c);
        int m;
        m = int'(stall_mode_i[2*c +: 2]);
        if (!en_stall_i) return 0;
        if (m == 1) return int'(fixed_stall_i[CNT_W*c +: CNT_W]);
`ifdef OBI_STALL_RANDOM_EN
        if (m == 2) return int'(m_lfsr[c][CNT_W-1:0]) % (int'(max_stall_i[CNT_W*c +: CNT_W]) + 1);
`endif
        return 0;
    endfunction

    // Inputs change only just after posedge, so at negedge they equal the
    // values the next posedge will sample: compare, then advance the model.
    always @(negedge clk_i) begin
        logic r, e_req, e_gnt, e_stall, is_open;
        cyc++;
        for (int c = 0; c < N_CH; c++) begin
            r = req_core_i[c];
            if (!rst_ni) begin
                act_tr[c] = 1'b0;
                m_cnt[c]  = 0;
                m_lfsr[c] = SEED ^ 32'(c);
                e_req = 1'b0; e_gnt = 1'b0; e_stall = 1'b0;
            end else begin
                if (r && !act_tr[c]) begin
                    act_tr[c]  = 1'b1;
                    t_start[c] = cyc;
                    dly[c]     = model_delay(c);
                    m_lfsr[c]  = m_lfsr_step(m_lfsr[c]);
                end
                is_open = act_tr[c] && (cyc >= t_start[c] + dly[c]);
                e_req   = r && is_open;
                e_gnt   = e_req && gnt_mem_i[c];
                e_stall = r && !e_gnt;
            end
            check($sformatf("ch%0d_reqmem_gnt_stall", c),
                  {29'd0, req_mem_o[c], gnt_core_o[c], stall_o[c]},
                  {29'd0, e_req, e_gnt, e_stall});
            check($sformatf("ch%0d_stall_cnt", c), 32'(stall_cnt_o[16*c +: 16]), 32'(m_cnt[c]));
            if (rst_ni) begin
                if (!r || e_gnt) act_tr[c] = 1'b0;
                if (clr_i)                      m_cnt[c] = 0;
                else if (e_stall && m_cnt[c] < 65535) m_cnt[c]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input int c, input logic [1:0] m, input logic [7:0] fx, input logic [7:0] mx);
        stall_mode_i[2*c +: 2]          = m;
        fixed_stall_i[CNT_W*c +: CNT_W] = fx;
        max_stall_i[CNT_W*c +: CNT_W]   = mx;
    endtask

    // Raise the selected requests (entered just after a posedge), hold each
    // until its first grant, return grant latency in cycles (-1 on timeout).
    task automatic req_pair(input logic r0, input logic r1, input int budget,
                            output int lat0, output int lat1);
        lat0 = -1; lat1 = -1;
        req_core_i = {r1, r0};
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_i);
            if (req_core_i[0] && gnt_core_o[0]) lat0 = k;
            if (req_core_i[1] && gnt_core_o[1]) lat1 = k;
            tick();
            if (lat0 >= 0) req_core_i[0] = 1'b0;
            if (lat1 >= 0) req_core_i[1] = 1'b0;
            if (req_core_i == '0) break;
        end
        req_core_i = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, gcount;
        int hist[5];
        rst_ni = 1'b0; clr_i = 1'b0; en_stall_i = 1'b0;
        stall_mode_i = '0; fixed_stall_i = '0; max_stall_i = '0;
        req_core_i = 2'b11; gnt_mem_i = 2'b11;

        // Reset holds all outputs low even with request and grant asserted.
        repeat (2) @(negedge clk_i);
        check("rst_req_mem", 32'(req_mem_o), 32'd0);
        check("rst_gnt_core", 32'(gnt_core_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        tick();
        req_core_i = '0; rst_ni = 1'b1;

        // Stall disabled, request in cycle 5: granted in the same cycle.
        repeat (5) tick();
        req_pair(1, 0, 10, l0, l1);
        check("nostall_lat", l0, 0);

        // STANDARD 3: grant at T+3, three stalled cycles counted.
        en_stall_i = 1'b1;
        set_cfg(0, 2'b01, 8'd3, 8'd0);
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        req_pair(1, 0, 20, l0, l1);
        check("std3_lat", l0, 3);
        @(negedge clk_i);
        check("std3_stall_cnt", 32'(stall_cnt_o[15:0]), 32'd3);
        tick();

        // Boundary delays and modes that collapse to zero.
        set_cfg(0, 2'b01, 8'd0, 8'd0);   req_pair(1, 0, 10, l0, l1);  check("std0_lat", l0, 0);
        set_cfg(0, 2'b01, 8'd1, 8'd0);   req_pair(1, 0, 10, l0, l1);  check("std1_lat", l0, 1);
        set_cfg(0, 2'b01, 8'd2, 8'd0);   req_pair(1, 0, 10, l0, l1);  check("std2_lat", l0, 2);
        set_cfg(0, 2'b01, 8'd255, 8'd0); req_pair(1, 0, 300, l0, l1); check("std255_lat", l0, 255);
        set_cfg(0, 2'b11, 8'd7, 8'd0);   req_pair(1, 0, 10, l0, l1);  check("rsvd_lat", l0, 0);
        en_stall_i = 1'b0;
        set_cfg(0, 2'b01, 8'd7, 8'd0);   req_pair(1, 0, 10, l0, l1);  check("disabled_lat", l0, 0);
        en_stall_i = 1'b1;

        // Simultaneous requests: ch1 NONE passes at once, ch0 STANDARD 5.
        set_cfg(0, 2'b01, 8'd5, 8'd0);
        set_cfg(1, 2'b00, 8'd9, 8'd0);
        req_pair(1, 1, 20, l0, l1);
        check("dual_ch0_lat", l0, 5);
        check("dual_ch1_lat", l1, 0);

        // Config changes during a stall are ignored.
        set_cfg(0, 2'b01, 8'd4, 8'd0);
        fork
            req_pair(1, 0, 20, l0, l1);
            begin
                tick(); tick();
                set_cfg(0, 2'b00, 8'd1, 8'd0);
                en_stall_i = 1'b0;
            end
        join
        check("cfg_frozen_lat", l0, 4);
        en_stall_i = 1'b1;

        // Zero delay but memory grant late: request stays open until granted.
        set_cfg(0, 2'b00, 8'd0, 8'd0);
        gnt_mem_i[0] = 1'b0;
        fork
            req_pair(1, 0, 10, l0, l1);
            begin tick(); tick(); gnt_mem_i[0] = 1'b1; end
        join
        check("late_gnt_lat", l0, 2);

        // Request dropped mid-stall, then re-issued: full delay again.
        set_cfg(0, 2'b01, 8'd4, 8'd0);
        req_core_i[0] = 1'b1; tick(); tick();
        req_core_i[0] = 1'b0; tick();
        req_pair(1, 0, 20, l0, l1);
        check("abort_relat", l0, 4);

        // Back-to-back on ch1 with STANDARD 2: grants in cycles 2, 5, 8.
        set_cfg(1, 2'b01, 8'd2, 8'd0);
        req_core_i[1] = 1'b1; gcount = 0;
        repeat (9) begin
            @(negedge clk_i);
            if (gnt_core_o[1]) gcount++;
            tick();
        end
        req_core_i[1] = 1'b0;
        check("b2b_grants", gcount, 3);
        tick();

        // Reset in cycle 2 of a 6-cycle stall, then a fresh 6-cycle stall.
        set_cfg(0, 2'b01, 8'd6, 8'd0);
        req_core_i[0] = 1'b1; tick(); tick();
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_outs", {29'd0, req_mem_o[0], gnt_core_o[0], stall_o[0]}, 32'd0);
        check("midrst_cnt", stall_cnt_o, 32'd0);
        tick();
        req_core_i[0] = 1'b0; rst_ni = 1'b1;
        tick();
        req_pair(1, 0, 20, l0, l1);
        check("postrst_lat", l0, 6);

        // RANDOM mode, bound 4.
        set_cfg(0, 2'b10, 8'd0, 8'd4);
`ifdef OBI_STALL_RANDOM_EN
        for (int v = 0; v < 5; v++) hist[v] = 0;
        for (int i = 0; i < 1000; i++) begin
            req_pair(1, 0, 20, l0, l1);
            check("rand_range", 32'(l0 >= 0 && l0 <= 4), 32'd1);
            if (l0 >= 0 && l0 <= 4) hist[l0]++;
        end
        for (int v = 0; v < 5; v++) check($sformatf("rand_hit_%0d", v), 32'(hist[v] > 0), 32'd1);
`else
        for (int v = 0; v < 5; v++) hist[v] = 0;
        for (int i = 0; i < 8; i++) begin
            req_pair(1, 0, 10, l0, l1);
            check("rand_off_lat", l0, 0);
            if (l0 >= 0 && l0 <= 4) hist[l0]++;
        end
        check("rand_off_all_zero", hist[0], 8);
`endif

        // Saturation: 70000 stalled cycles, then clr_i wins over increment.
        set_cfg(0, 2'b00, 8'd0, 8'd0);
        gnt_mem_i[0] = 1'b0;
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        req_core_i[0] = 1'b1;
        repeat (70000) tick();
        @(negedge clk_i);
        check("sat_cnt", 32'(stall_cnt_o[15:0]), 32'h0000_FFFF);
        tick(); tick();
        @(negedge clk_i);
        check("sat_hold", 32'(stall_cnt_o[15:0]), 32'h0000_FFFF);
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        @(negedge clk_i);
        check("clr_cnt", 32'(stall_cnt_o[15:0]), 32'd0);
        tick();
        @(negedge clk_i);
        check("post_clr_cnt", 32'(stall_cnt_o[15:0]), 32'd1);
        tick();
        req_core_i = '0; gnt_mem_i = 2'b11;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
